// File: rtl/div_16_pkg.sv
// Shared constants and state encoding for the 16-bit restoring divider.
package div_16_pkg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/ADDSUB_16.sv
// 16-bit adder/subtractor: S = X + Y (Sub=0) or X - Y (Sub=1); Cout=1 on subtract means no borrow.
module ADDSUB_16 (
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic        Sub,
  output logic [15:0] S,
  output logic        Cout
);
  logic [15:0] y_eff;
  logic [16:0] sum;

  assign y_eff       = Y ^ {16{Sub}};
  assign sum         = {1'b0, X} + {1'b0, y_eff} + {16'd0, Sub};
  assign {Cout, S}   = sum;
endmodule

// File: rtl/div_16.sv
// Unsigned 16-bit restoring divider, one quotient bit per clock, Start/Busy/Done handshake.
// Accept -> 16 RUN cycles -> 1-cycle DONE pulse; divide-by-zero skips RUN entirely.
module div_16
  import div_16_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DivZero
);
  state_t            state, state_nxt;
  logic [WIDTH-1:0]  qs, pr, d;
  logic [CNT_W-1:0]  cnt;

  logic [WIDTH-1:0]  sh, diff, pr_step, qs_step;
  logic              cout, qb;

  // Shifted partial remainder; its dropped top bit (pr[15]) is the 17th bit of the trial value.
  assign sh = {pr[WIDTH-2:0], qs[WIDTH-1]};

  ADDSUB_16 u_addsub (
    .X    (sh),
    .Y    (d),
    .Sub  (1'b1),
    .S    (diff),
    .Cout (cout)
  );

  assign qb      = pr[WIDTH-1] | cout;
  assign pr_step = qb ? diff : sh;
  assign qs_step = {qs[WIDTH-2:0], qb};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = (Y == '0) ? S_DONE : S_RUN;
      S_RUN:   if (cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign Busy = (state == S_RUN);
  assign Done = (state == S_DONE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      qs      <= '0;
      pr      <= '0;
      d       <= '0;
      cnt     <= '0;
      Q       <= '0;
      R       <= '0;
      DivZero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (Y == '0) begin
              Q       <= '1;
              R       <= X;
              DivZero <= 1'b1;
            end else begin
              d       <= Y;
              qs      <= X;
              pr      <= '0;
              cnt     <= '0;
              DivZero <= 1'b0;
            end
          end
        end
        S_RUN: begin
          pr  <= pr_step;
          qs  <= qs_step;
          cnt <= cnt + CNT_W'(1);
          // Results are captured on the final step so they are valid with Done.
          if (cnt == CNT_LAST) begin
            Q <= qs_step;
            R <= pr_step;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_16.sv
// Self-checking bench for div_16: directed cases, timing, handshake corner cases and random operands.
module tb_div_16;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] X = '0;
  logic [15:0] Y = '0;
  logic        Busy, Done, DivZero;
  logic [15:0] Q, R;

  int tests = 0;
  int fails = 0;

  div_16 dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .X(X), .Y(Y),
    .Busy(Busy), .Done(Done), .Q(Q), .R(R), .DivZero(DivZero)
  );

  always #5 Clk = ~Clk;

  // Reference: plain integer division, with the divide-by-zero convention.
  function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] q, output logic [15:0] r, output logic dz);
    if (y == 16'd0) begin
      q = 16'hFFFF; r = x; dz = 1'b1;
    end else begin
      q = x / y; r = x % y; dz = 1'b0;
    end
  endfunction

  // Issues one Start pulse and returns when Done is seen (or the budget expires).
  // lat counts edges from the accepting edge (1) to the edge after which Done is high.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        output int lat, output int nbusy, output bit overlap);
    lat = 0; nbusy = 0; overlap = 1'b0;
    X = x; Y = y; Start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
      if (Busy) nbusy++;
      if (Busy && Done) overlap = 1'b1;
      if (Done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({Busy, Done, DivZero, Q, R} !== 35'd0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b dz=%b q=%h r=%h, want all 0", Busy, Done, DivZero, Q, R);
    end
    @(posedge Clk); #1; Rst_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] xs[4] = '{16'd136, 16'hFFFF, 16'd1000, 16'd3};
    logic [15:0] ys[4] = '{16'd17, 16'hFFFE, 16'd7, 16'hFFFF};
    logic [15:0] eq[4] = '{16'd8, 16'd1, 16'd142, 16'd0};
    logic [15:0] er[4] = '{16'd0, 16'd1, 16'd6, 16'd3};
    int lat, nbusy; bit ov;
    for (int i = 0; i < 4; i++) begin
      run_op(xs[i], ys[i], lat, nbusy, ov);
      tests++;
      if (Q !== eq[i] || R !== er[i] || DivZero !== 1'b0) begin
        fails++;
        $display("FAIL directed_%0d: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=0", i, Q, R, DivZero, eq[i], er[i]);
      end
      tests++;
      if (lat !== 17 || nbusy !== 16 || ov) begin
        fails++;
        $display("FAIL timing_%0d: got lat=%0d busy_cycles=%0d overlap=%b, want 17/16/0", i, lat, nbusy, ov);
      end
      @(posedge Clk); #1;
      tests++;
      if (Done !== 1'b0 || Q !== eq[i]) begin
        fails++;
        $display("FAIL done_pulse_hold_%0d: got done=%b q=%0d, want done=0 q=%0d", i, Done, Q, eq[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, nbusy; bit ov;
    run_op(16'd5, 16'd0, lat, nbusy, ov);
    tests++;
    if (lat !== 1 || nbusy !== 0 || Q !== 16'hFFFF || R !== 16'd5 || DivZero !== 1'b1) begin
      fails++;
      $display("FAIL div_zero: got lat=%0d busy=%0d q=%h r=%0d dz=%b, want 1/0/ffff/5/1", lat, nbusy, Q, R, DivZero);
    end
    @(posedge Clk); #1;
    run_op(16'd9, 16'd3, lat, nbusy, ov);
    tests++;
    if (Q !== 16'd3 || R !== 16'd0 || DivZero !== 1'b0 || lat !== 17) begin
      fails++;
      $display("FAIL div_zero_clear: got q=%0d r=%0d dz=%b lat=%0d, want 3/0/0/17", Q, R, DivZero, lat);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_ignore_start();
    int lat;
    lat = 0;
    X = 16'd136; Y = 16'd17; Start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk); #1;
      Start = (k == 3);
      if (k == 3) begin X = 16'd1000; Y = 16'd7; end
      if (Done) begin lat = k; break; end
    end
    tests++;
    if (lat !== 17 || Q !== 16'd8 || R !== 16'd0) begin
      fails++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d, want 17/8/0", lat, Q, R);
    end
    @(posedge Clk); #1;
    tests++;
    if (Busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_start_idle: got busy=%b, want 0", Busy);
    end
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    X = 16'd136; Y = 16'd17; Start = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(posedge Clk); #1;
      if (Done) begin
        done_at.push_back(k);
        if (done_at.size() == 3) begin Start = 1'b0; break; end
      end
    end
    tests++;
    if (done_at.size() != 3) begin
      fails++;
      $display("FAIL back_to_back_count: got %0d done pulses, want 3", done_at.size());
    end else begin
      if (done_at[0] != 17 || done_at[1] - done_at[0] != 18 || done_at[2] - done_at[1] != 18 || Q !== 16'd8) begin
        fails++;
        $display("FAIL back_to_back_interval: got done at %0d,%0d,%0d q=%0d, want 17,35,53 q=8",
                 done_at[0], done_at[1], done_at[2], Q);
      end
    end
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int lat, nbusy; bit ov, seen;
    seen = 1'b0;
    X = 16'd1000; Y = 16'd7; Start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
    end
    #2; Rst_n = 1'b0; #1;
    tests++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Q !== 16'd0 || R !== 16'd0 || DivZero !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_run: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0", Busy, Done, Q, R, DivZero);
    end
    repeat (2) @(posedge Clk);
    #1; Rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk); #1;
      if (Done || Busy) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL reset_abort: got busy/done activity after abort, want none");
    end
    run_op(16'd100, 16'd9, lat, nbusy, ov);
    tests++;
    if (Q !== 16'd11 || R !== 16'd1 || lat !== 17) begin
      fails++;
      $display("FAIL after_reset: got q=%0d r=%0d lat=%0d, want 11/1/17", Q, R, lat);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_random();
    logic [15:0] x, y, eq, er;
    logic edz;
    int lat, nbusy; bit ov;
    for (int i = 0; i < 60; i++) begin
      x = 16'($urandom);
      case ($urandom_range(0, 3))
        0: y = 16'($urandom_range(0, 15));
        1: y = 16'($urandom_range(16'h8000, 16'hFFFF));
        default: y = 16'($urandom);
      endcase
      model(x, y, eq, er, edz);
      run_op(x, y, lat, nbusy, ov);
      tests++;
      if (Q !== eq || R !== er || DivZero !== edz || lat !== (edz ? 1 : 17) || ov) begin
        fails++;
        $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d dz=%b lat=%0d, want q=%0d r=%0d dz=%b lat=%0d",
                 i, x, y, Q, R, DivZero, lat, eq, er, edz, edz ? 1 : 17);
      end
      if ($urandom_range(0, 1) == 1) begin @(posedge Clk); #1; end
      else begin @(posedge Clk); #1; @(posedge Clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
